// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
// Holds the FSM state encoding, bus widths and the address legality check.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // An address is usable when it is word aligned and falls inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_words);
        logic [33:0] limit;
        limit = 34'(depth_words) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-organised RAM with per-byte write enables and combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we && wstrb[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's data port: one request at a time, fixed access latency.
// state | meaning
// IDLE  | req_ready high, waiting for a request to latch
// WAIT  | latency down-counter running; access happens when it reaches zero
// RESP  | response held on rsp_* until the initiator takes it
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic              access_ok;

    assign access_ok = addr_ok(addr_q, DEPTH_WORDS);

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wstrb (wstrb_q),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        arr_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Store commits on this edge, so the array is current before rsp_valid rises.
                    arr_we      = access_ok && write_q;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !access_ok;
                    rsp_rdata_d = (access_ok && !write_q) ? arr_rdata : '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder (slave) side of the core's data-memory port. It replaces the zero-latency combinational data memory with a handshaked, multi-cycle memory model.
- Accepts one load/store request at a time over a valid/ready request channel.
- Performs the access after a configurable latency.
- Returns read data and an error flag over a valid/ready response channel.
- Sits at the MEM stage boundary; the core's load/store path is the initiator.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=2)
LATENCY, 2, clock edges from request acceptance to response valid (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  initiator presents a request
req_ready  out  1  responder can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_wstrb  in  4  byte-lane enables for stores, bit i = bits [8i+7:8i]
rsp_valid  out  1  response available
rsp_ready  in  1  initiator accepts response
rsp_rdata  out  32  load data; 0 for stores and errored requests
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0, latched request cleared. req_ready=1 once reset deasserts. Array contents are not reset.
- States:
  - IDLE: req_ready=1. On an edge with req_valid=1, the request is accepted. Latch write, addr, wdata, wstrb; load cnt=LATENCY-1; go to WAIT. req_valid=0 -> stay in IDLE.
  - WAIT: req_ready=0. If cnt!=0, cnt-- at each edge. If cnt==0, perform the access at that edge and go to RESP with rsp_valid=1. rsp_valid therefore rises exactly LATENCY edges after the accepting edge.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready. On that edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE. rsp_ready is sampled only in RESP.
- One outstanding transaction. Best-case throughput is one request per LATENCY+2 cycles.
- Addressing: word index = addr[log2(DEPTH_WORDS)+1:2].
- Error conditions, each giving err=1, rdata=0, and no array write:
  - addr[1:0]!=0 (misaligned)
  - addr >= DEPTH_WORDS*4 (out of range)
- Load: full 32-bit word returned; wstrb ignored.
- Store: only lanes with wstrb=1 are updated; rdata=0, err=0. wstrb=0000 is a legal no-op store with err=0.
- Ordering: a load issued after a store's response returns the stored data (no forwarding window; the array is written before rsp_valid rises).
- Reset mid-transaction (WAIT or RESP): the transaction is discarded. A store in WAIT is not committed; a store already in RESP stays committed.
- req_* inputs are ignored outside IDLE. Latched values, not live inputs, are used for the access.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding enum {IDLE, WAIT, RESP}
  - DATA_W=32, STRB_W=4
  - address-check helper function (aligned / in-range)
- Sub-module dmem_array: single-port synchronous RAM, DEPTH_WORDS x 32.
  - Per-byte write enable, combinational read.
  - Instantiated once by dmem_responder, which owns the FSM, counter, latches and error logic.

Test Plan:
1. LATENCY=2. Reset, then store 0xDEADBEEF to 0x10 with wstrb=1111, then load 0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid rises exactly 2 edges after each accepting edge.
2. After test 1, store 0x0000AA00 to 0x10 with wstrb=0010, then load 0x10. Required: rsp_rdata=0xDEADAAEF.
3. Store 0x12345678 to 0x13 (misaligned), then load 0x10. Required: first response err=1, rdata=0; second response rdata=0xDEADAAEF.
4. DEPTH_WORDS=1024, load 0x00001000. Required: err=1, rdata=0. Then load 0x00000FFC. Required: err=0.
5. Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 with a new address. Required: rsp_valid=1 and rsp_rdata stable throughout, req_ready=0, new request not accepted until one cycle after the rsp handshake.
6. Assert reset in WAIT of a store of 0xCAFEF00D to 0x20 (prior value 0x11111111), then load 0x20. Required: outputs zero during reset, load returns 0x11111111.
